// File: rtl/sum_bcd_converter_if.sv
// Handshake and result bundle between the adder sum source, the BCD converter
// and the display consumer.
interface sum_bcd_converter_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] in_value;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Producer/consumer side: drives the input value and accepts results.
  modport master (
    output in_value,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  hundreds,
    input  tens,
    input  ones,
    input  out_valid,
    input  busy
  );

  // Converter side.
  modport slave (
    input  in_value,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output hundreds,
    output tens,
    output ones,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts one value in IDLE, shifts WIDTH times, then holds the three digits
// in DONE until the consumer takes them.
module sum_bcd_converter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  sum_bcd_converter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [11:0]      work_q;
  logic [WIDTH-1:0] shift_q;
  logic [3:0]       count_q;

  logic [3:0] hundreds_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic       out_valid_q;

  logic load;
  logic shift_en;
  logic finish;
  logic done_ack;
  logic last_bit;

  logic [11:0] adj;
  logic [11:0] work_shift;
  logic        unused_adj_msb;

  assign last_bit = (count_q == 4'(WIDTH - 1));

  // Add-3 correction on every digit in parallel, then shift in the binary MSB.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    work_shift = {adj[10:0], shift_q[WIDTH-1]};
  end

  // Inputs never exceed 255, so the hundreds digit never carries out.
  assign unused_adj_msb = adj[11];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    done_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (last_bit) begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // A pending in_valid is not taken here; it waits for IDLE.
        if (bus.out_ready) begin
          done_ack = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Work register, binary shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q  <= '0;
      shift_q <= '0;
      count_q <= '0;
    end else if (load) begin
      work_q  <= '0;
      shift_q <= bus.in_value;
      count_q <= '0;
    end else if (shift_en) begin
      work_q  <= work_shift;
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      count_q <= count_q + 4'd1;
    end
  end

  // Output digits capture the final shift result directly; retained after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hundreds_q <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
    end else if (finish) begin
      hundreds_q <= work_shift[11:8];
      tens_q     <= work_shift[7:4];
      ones_q     <= work_shift[3:0];
    end
  end

  // Result-valid flag: set on the last shift, cleared when the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else if (finish) begin
      out_valid_q <= 1'b1;
    end else if (done_ack) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.hundreds  = hundreds_q;
  assign bus.tens      = tens_q;
  assign bus.ones      = ones_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Scoreboard bench for sum_bcd_converter: stimulus pushes the arithmetic
// expectation, a negedge monitor pops on each new result.
module tb_sum_bcd_converter;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;

  sum_bcd_converter_if #(.WIDTH(WIDTH)) bus ();

  sum_bcd_converter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int t;
    int o;
    int acc;
  } exp_t;

  exp_t sb[$];

  int total;
  int bad;
  int cyc;
  int rise_cyc;
  int prev_rise_cyc;
  int rand_rdy;
  int held_h, held_t, held_o;
  logic prev_ov;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every rising out_valid; check stability while held.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hundreds", int'(bus.hundreds), e.h);
          chk("tens", int'(bus.tens), e.t);
          chk("ones", int'(bus.ones), e.o);
          chk("latency", cyc - e.acc, WIDTH);
        end
        held_h = int'(bus.hundreds);
        held_t = int'(bus.tens);
        held_o = int'(bus.ones);
        prev_rise_cyc = rise_cyc;
        rise_cyc = cyc;
      end else if (bus.out_valid && prev_ov) begin
        chk("held_digits", int'({bus.hundreds, bus.tens, bus.ones}),
            (held_h << 8) | (held_t << 4) | held_o);
      end
      prev_ov = bus.out_valid;
    end
  end

  // Random consumer back-pressure when enabled.
  always @(negedge clk) begin
    if (rand_rdy != 0) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Present v from the current negedge until accepted; leaves in_valid high.
  task automatic send(input int v);
    int n;
    n = 0;
    bus.in_value = WIDTH'(v);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", n, 0);
    end else begin
      sb.push_back('{h: v / 100, t: (v / 10) % 10, o: v % 10, acc: cyc + 1});
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_value = WIDTH'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.in_ready && !bus.out_valid && sb.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", n, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rise_cyc = 0;
    prev_rise_cyc = 0;
    rand_rdy = 0;
    prev_ov = 1'b0;
    rst = 1'b1;
    bus.in_value = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(bus.in_ready), 1);

    // 255: in_ready drops after the accept edge.
    send(255);
    idle_in();
    chk("busy_after_accept", int'(bus.busy), 1);
    chk("in_ready_after_accept", int'(bus.in_ready), 0);
    wait_idle();

    // Small values and the add-3 boundary.
    send(0); idle_in(); wait_idle();
    send(9); idle_in(); wait_idle();
    send(10); idle_in(); wait_idle();

    // 199 held in DONE with out_ready low.
    bus.out_ready = 1'b0;
    send(199);
    idle_in();
    repeat (WIDTH + 2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ack_out_valid", int'(bus.out_valid), 0);
    chk("ack_in_ready", int'(bus.in_ready), 1);
    chk("ack_digits", int'({bus.hundreds, bus.tens, bus.ones}), 12'h199);
    repeat (3) @(negedge clk);
    chk("ack_digits_kept", int'({bus.hundreds, bus.tens, bus.ones}), 12'h199);
    bus.out_ready = 1'b1;

    // 77 pulsed while converting 123 must be dropped.
    send(123);
    bus.in_value = WIDTH'(77);
    chk("busy_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    idle_in();
    wait_idle();
    repeat (4) @(negedge clk);
    chk("no_extra_result", int'(bus.out_valid), 0);

    // Asynchronous reset mid-conversion (4th shift cycle).
    send(200);
    idle_in();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    chk("post_rst_no_result", int'(bus.out_valid), 0);
    send(42); idle_in(); wait_idle();

    // Back-to-back with in_valid held: results 10 cycles apart.
    send(100);
    send(56);
    idle_in();
    wait_idle();
    chk("b2b_spacing", rise_cyc - prev_rise_cyc, WIDTH + 2);

    // Random values with random back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 255)));
      idle_in();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the 8-bit ripple adder and consumes its sum Y.
- Uses shift-and-add-3 (double dabble), one bit per clock, with a valid/ready handshake on both sides.
- Produces hundreds, tens and ones digits for the display stage.

Parameters:
- WIDTH, 8, input width in bits. Legal range is 4..8 so that 3 BCD digits always suffice. Shift count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_value  input  WIDTH  unsigned binary value (the adder sum Y).
- in_valid  input  1  in_value is valid this cycle.
- in_ready  output  1  converter can accept; combinational, equals (state==IDLE) && !rst.
- hundreds  output  4  BCD hundreds digit, registered.
- tens  output  4  BCD tens digit, registered.
- ones  output  4  BCD ones digit, registered.
- out_valid  output  1  digits hold a completed conversion awaiting consumption; registered.
- out_ready  input  1  consumer accepts the result this cycle.
- busy  output  1  high in SHIFT and DONE; combinational from state.

Behaviour:
- Reset (asynchronous, active-high, applies at any time including mid-conversion):
  - state=IDLE; hundreds, tens, ones = 0; out_valid=0.
  - Internal shift register and bit counter cleared.
  - In-flight conversion discarded; no partial result ever appears.
- Internal state: 12-bit BCD work register, WIDTH-bit binary shift register, 4-bit bit counter. The work register is never visible on the outputs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load the shift register with in_value, clear the work register, set count=0, go to SHIFT.
  - Output digits keep their previous values.
- SHIFT, once per cycle:
  - Each work digit >=5 gets +3 (all three digits adjusted in parallel, before the shift).
  - Then {work, shift} shifts left by 1; the binary MSB enters work bit 0.
  - count increments.
  - On the edge where count==WIDTH-1, the final shift result is written to hundreds/tens/ones, out_valid is set to 1, and state goes to DONE.
- DONE:
  - Digits stable, out_valid=1.
  - On an edge with out_ready=1: out_valid goes to 0, state goes to IDLE. Digits are retained (not cleared) until the next DONE entry.
  - out_ready=0 holds DONE indefinitely with outputs unchanged.
- Latency: accept edge E0; shift edges E1..EWIDTH; out_valid first high after edge EWIDTH (8 cycles for WIDTH=8).
- Throughput: with out_ready tied high, one conversion per WIDTH+2 cycles (10 cycles for WIDTH=8).
- Boundary conditions:
  - in_valid while busy: ignored. in_ready=0, and the value is not queued.
  - out_ready while not in DONE: ignored.
  - in_valid and out_ready both high in DONE: only the DONE->IDLE transition occurs. The input is not accepted that edge and must be held to the next cycle.
  - in_value is sampled only at the accept edge; later changes have no effect.
  - Maximum input 255 gives hundreds=2, so the top 2 bits of hundreds are always 0. Digits never exceed 9.
  - WIDTH<8: the input is zero-extended conceptually; the shift count equals WIDTH.

Test Plan:
- Reset then in_value=8'd255, in_valid for 1 cycle -> in_ready drops next cycle. Exactly 8 cycles after the accept edge: out_valid=1, hundreds=2, tens=5, ones=5.
- in_value=0 -> 0/0/0 after 8 cycles. in_value=9 -> 0/0/9. in_value=10 -> 0/1/0, which exercises the add-3 boundary at digit value 5.
- in_value=199 with out_ready=0 for 20 cycles -> out_valid stays 1 and 1/9/9 stays stable. Raising out_ready for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle, with digits still 1/9/9.
- in_valid pulsed with value 77 during SHIFT of a conversion of 123 -> result 1/2/3 only; 77 is never converted.
- Assert rst asynchronously (mid-cycle) during the 4th SHIFT cycle -> outputs immediately 0 and out_valid=0. After release, converting 42 yields 0/4/2.
- Back-to-back 100 then 56 with out_ready=1 and in_valid held -> results 1/0/0 then 0/5/6, with out_valid rising edges exactly 10 cycles apart.
